// File: rtl/riscv_fetch_pkg.sv
// Shared constants for the instruction-fetch slice.
package riscv_fetch_pkg;

  localparam int          INST_W   = 32;
  localparam int          PC_STEP  = 4;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

endpackage

// File: rtl/riscv_fetch_fifo.sv
// Synchronous FIFO with a registered head stage, synchronous flush and occupancy count.
module riscv_fetch_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_flush,
  input  logic                       i_push,
  input  logic [W-1:0]               i_data,
  input  logic                       i_pop,
  output logic                       o_valid,
  output logic [W-1:0]               o_data,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [CW-1:0] r_scnt;
  logic [W-1:0]  r_head;
  logic          r_hvalid;

  logic w_pop;
  logic w_head_free;
  logic w_from_store;
  logic w_direct;
  logic w_store_wr;

  // The head register refills from storage first; an empty storage lets a push go straight to the head.
  assign w_pop        = i_pop & r_hvalid;
  assign w_head_free  = ~r_hvalid | w_pop;
  assign w_from_store = w_head_free & (r_scnt != '0);
  assign w_direct     = w_head_free & (r_scnt == '0) & i_push;
  assign w_store_wr   = i_push & ~w_direct;

  assign o_valid = r_hvalid;
  assign o_data  = r_head;
  assign o_count = r_scnt + CW'(r_hvalid);

  always_ff @(posedge clk) begin
    if (!i_flush && w_store_wr) begin
      r_mem[r_wr] <= i_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr     <= '0;
      r_rd     <= '0;
      r_scnt   <= '0;
      r_head   <= '0;
      r_hvalid <= 1'b0;
    end else if (i_flush) begin
      r_wr     <= '0;
      r_rd     <= '0;
      r_scnt   <= '0;
      r_head   <= '0;
      r_hvalid <= 1'b0;
    end else begin
      if (w_store_wr) begin
        r_wr <= r_wr + AW'(1);
      end
      if (w_from_store) begin
        r_rd <= r_rd + AW'(1);
      end
      r_scnt <= r_scnt + CW'(w_store_wr) - CW'(w_from_store);
      if (w_from_store) begin
        r_head   <= r_mem[r_rd];
        r_hvalid <= 1'b1;
      end else if (w_direct) begin
        r_head   <= i_data;
        r_hvalid <= 1'b1;
      end else if (w_head_free) begin
        r_hvalid <= 1'b0;
      end else begin
        r_hvalid <= r_hvalid;
      end
    end
  end

endmodule

// File: rtl/riscv_ifetch_pf_chk.sv
// Protocol checks for the fetch unit's memory port.
module riscv_ifetch_pf_chk #(
  parameter int CW = 3
) (
  input logic          clk,
  input logic          rst,
  input logic          i_rvalid,
  input logic [CW-1:0] i_outstanding,
  input logic          i_req,
  input logic          i_redirect
);

  a_rvalid_without_request: assert property (
    @(posedge clk) disable iff (rst) i_rvalid |-> (i_outstanding != '0));

  a_no_req_during_redirect: assert property (
    @(posedge clk) disable iff (rst) i_redirect |-> !i_req);

endmodule

// File: rtl/riscv_ifetch_pf.sv
// Prefetching fetch unit: credit-limited request/grant port feeding a buffered valid/ready instruction stream.
module riscv_ifetch_pf
  import riscv_fetch_pkg::*;
#(
  parameter int               XLEN       = 32,
  parameter logic [XLEN-1:0]  RESET_PC   = '0,
  parameter int               FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_redirect_valid,
  input  logic [XLEN-1:0]   i_redirect_pc,
  output logic              o_imem_req,
  output logic [XLEN-1:0]   o_imem_addr,
  input  logic              i_imem_gnt,
  input  logic              i_imem_rvalid,
  input  logic [INST_W-1:0] i_imem_rdata,
  output logic              o_inst_valid,
  output logic [INST_W-1:0] o_inst,
  output logic [XLEN-1:0]   o_inst_pc,
  output logic [XLEN-1:0]   o_inst_pc_plus_4,
  input  logic              i_inst_ready
);

  localparam int              CW   = $clog2(FIFO_DEPTH+1);
  localparam int              FW   = XLEN + INST_W;
  localparam logic [XLEN-1:0] STEP = XLEN'(PC_STEP);

  logic [XLEN-1:0] r_fetch_pc;
  logic [XLEN-1:0] r_resp_pc;
  logic [CW-1:0]   r_outstanding;
  logic [CW-1:0]   r_drop_cnt;

  logic [CW-1:0]   w_fifo_count;
  logic [CW:0]     w_inflight;
  logic            w_accept;
  logic            w_push;
  logic            w_pop;
  logic [CW-1:0]   w_out_next;
  logic [XLEN-1:0] w_redir_pc;
  logic [FW-1:0]   w_head;
  logic            w_head_valid;

  // Outstanding requests plus buffered words may never exceed the buffer size, so pushes cannot overflow.
  assign w_inflight = {1'b0, r_outstanding} + {1'b0, w_fifo_count};
  assign o_imem_req = !rst && !i_redirect_valid && (w_inflight < (CW+1)'(FIFO_DEPTH));
  assign o_imem_addr = r_fetch_pc;

  assign w_accept   = o_imem_req & i_imem_gnt;
  assign w_push     = i_imem_rvalid & (r_drop_cnt == '0) & ~i_redirect_valid;
  assign w_pop      = w_head_valid & i_inst_ready & ~i_redirect_valid;
  assign w_out_next = r_outstanding + CW'(w_accept) - CW'(i_imem_rvalid);
  assign w_redir_pc = i_redirect_pc & ~XLEN'(3);

  // drop_cnt is a subset of outstanding, so after a redirect every remaining in-flight response is stale.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_pc    <= RESET_PC;
      r_resp_pc     <= RESET_PC;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
    end else if (i_redirect_valid) begin
      r_fetch_pc    <= w_redir_pc;
      r_resp_pc     <= w_redir_pc;
      r_outstanding <= w_out_next;
      r_drop_cnt    <= w_out_next;
    end else begin
      if (w_accept) begin
        r_fetch_pc <= r_fetch_pc + STEP;
      end
      r_outstanding <= w_out_next;
      if (i_imem_rvalid && (r_drop_cnt != '0)) begin
        r_drop_cnt <= r_drop_cnt - CW'(1);
      end else if (i_imem_rvalid) begin
        r_resp_pc <= r_resp_pc + STEP;
      end
    end
  end

  riscv_fetch_fifo #(
    .W     (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_flush (i_redirect_valid),
    .i_push  (w_push),
    .i_data  ({r_resp_pc, i_imem_rdata}),
    .i_pop   (w_pop),
    .o_valid (w_head_valid),
    .o_data  (w_head),
    .o_count (w_fifo_count)
  );

  assign o_inst_valid     = w_head_valid;
  assign o_inst           = w_head[INST_W-1:0];
  assign o_inst_pc        = w_head[FW-1:INST_W];
  assign o_inst_pc_plus_4 = w_head_valid ? (w_head[FW-1:INST_W] + STEP) : '0;

  riscv_ifetch_pf_chk #(
    .CW (CW)
  ) u_chk (
    .clk           (clk),
    .rst           (rst),
    .i_rvalid      (i_imem_rvalid),
    .i_outstanding (r_outstanding),
    .i_req         (o_imem_req),
    .i_redirect    (i_redirect_valid)
  );

endmodule

// File: tb/tb_riscv_ifetch_pf.sv
// Directed bench for riscv_ifetch_pf with a queued-latency memory model.
module tb_riscv_ifetch_pf;

  localparam logic [31:0] K = 32'h1357_9BDF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_redirect_valid = 1'b0;
  logic [31:0] i_redirect_pc = 32'h0;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_gnt = 1'b1;
  logic        i_imem_rvalid = 1'b0;
  logic [31:0] i_imem_rdata = 32'h0;
  logic        o_inst_valid;
  logic [31:0] o_inst;
  logic [31:0] o_inst_pc;
  logic [31:0] o_inst_pc_plus_4;
  logic        i_inst_ready = 1'b0;

  always #5 clk = ~clk;

  riscv_ifetch_pf #(.XLEN(32), .RESET_PC(32'h0), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .i_redirect_valid(i_redirect_valid), .i_redirect_pc(i_redirect_pc),
    .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr), .i_imem_gnt(i_imem_gnt),
    .i_imem_rvalid(i_imem_rvalid), .i_imem_rdata(i_imem_rdata),
    .o_inst_valid(o_inst_valid), .o_inst(o_inst), .o_inst_pc(o_inst_pc),
    .o_inst_pc_plus_4(o_inst_pc_plus_4), .i_inst_ready(i_inst_ready)
  );

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int cyc      = 0;
  int lat      = 1;
  int first_v  = -1;
  int first_g  = -1;
  logic [31:0] q_addr[$];
  int          q_due[$];
  logic [31:0] g_addr[$];
  logic [31:0] p_pc[$];
  logic [31:0] p_pc4[$];
  logic [31:0] p_inst[$];

  task automatic tick();
    #1;
    if (o_imem_req && i_imem_gnt) begin
      q_addr.push_back(o_imem_addr);
      q_due.push_back(cyc + lat);
      g_addr.push_back(o_imem_addr);
      if (first_g < 0) first_g = cyc;
    end
    if (o_inst_valid && first_v < 0) first_v = cyc;
    if (o_inst_valid && i_inst_ready && !i_redirect_valid) begin
      p_pc.push_back(o_inst_pc);
      p_pc4.push_back(o_inst_pc_plus_4);
      p_inst.push_back(o_inst);
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (q_due.size() > 0 && q_due[0] <= cyc) begin
      i_imem_rvalid = 1'b1;
      i_imem_rdata  = q_addr[0] ^ K;
      void'(q_addr.pop_front());
      void'(q_due.pop_front());
    end else begin
      i_imem_rvalid = 1'b0;
      i_imem_rdata  = 32'h0;
    end
  endtask

  task automatic clear_logs();
    g_addr.delete(); p_pc.delete(); p_pc4.delete(); p_inst.delete();
    first_v = -1; first_g = -1;
  endtask

  task automatic reset_all();
    rst = 1'b1;
    i_redirect_valid = 1'b0; i_inst_ready = 1'b0; i_imem_rvalid = 1'b0; i_imem_gnt = 1'b1;
    q_addr.delete(); q_due.delete(); clear_logs();
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic test_reset();
    #1;
    chk_cnt++; if (o_imem_req !== 1'b0) $display("FAIL reset_req: got %0b expected 0", o_imem_req); else pass_cnt++;
    chk_cnt++; if (o_inst_valid !== 1'b0) $display("FAIL reset_valid: got %0b expected 0", o_inst_valid); else pass_cnt++;
    chk_cnt++; if (o_inst !== 32'h0) $display("FAIL reset_inst: got %h expected 0", o_inst); else pass_cnt++;
    chk_cnt++; if (o_inst_pc !== 32'h0) $display("FAIL reset_pc: got %h expected 0", o_inst_pc); else pass_cnt++;
    chk_cnt++; if (o_inst_pc_plus_4 !== 32'h0) $display("FAIL reset_pc4: got %h expected 0", o_inst_pc_plus_4); else pass_cnt++;
  endtask

  task automatic test_stream();
    logic [31:0] exp_pc [3] = '{32'h0, 32'h4, 32'h8};
    logic [31:0] exp_pc4[3] = '{32'h4, 32'h8, 32'hC};
    reset_all(); lat = 1; i_inst_ready = 1'b1;
    repeat (8) tick();
    for (int i = 0; i < 3; i++) begin
      chk_cnt++; if (g_addr[i] !== exp_pc[i]) $display("FAIL stream_addr%0d: got %h expected %h", i, g_addr[i], exp_pc[i]); else pass_cnt++;
      chk_cnt++; if (p_pc[i] !== exp_pc[i]) $display("FAIL stream_pc%0d: got %h expected %h", i, p_pc[i], exp_pc[i]); else pass_cnt++;
      chk_cnt++; if (p_pc4[i] !== exp_pc4[i]) $display("FAIL stream_pc4_%0d: got %h expected %h", i, p_pc4[i], exp_pc4[i]); else pass_cnt++;
    end
    chk_cnt++; if (first_v - first_g != 2) $display("FAIL stream_latency: got %0d expected 2", first_v - first_g); else pass_cnt++;
    chk_cnt++; if (p_inst[0] !== K) $display("FAIL stream_inst: got %h expected %h", p_inst[0], K); else pass_cnt++;
    chk_cnt++; if (p_pc.size() != 6) $display("FAIL stream_throughput: got %0d pops expected 6", p_pc.size()); else pass_cnt++;
  endtask

  task automatic test_stall();
    int unstable = 0;
    logic [31:0] exp_pc[4] = '{32'h0, 32'h4, 32'h8, 32'hC};
    reset_all(); lat = 1; i_inst_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (o_inst_valid && (o_inst_pc !== 32'h0 || o_inst !== K)) unstable++;
    end
    #1;
    chk_cnt++; if (g_addr.size() != 4) $display("FAIL stall_grants: got %0d expected 4", g_addr.size()); else pass_cnt++;
    chk_cnt++; if (o_imem_req !== 1'b0) $display("FAIL stall_req: got %0b expected 0", o_imem_req); else pass_cnt++;
    chk_cnt++; if (o_inst_valid !== 1'b1) $display("FAIL stall_valid: got %0b expected 1", o_inst_valid); else pass_cnt++;
    chk_cnt++; if (unstable != 0) $display("FAIL stall_stable: got %0d changes expected 0", unstable); else pass_cnt++;
    i_inst_ready = 1'b1;
    repeat (6) tick();
    for (int i = 0; i < 4; i++) begin
      chk_cnt++; if (p_pc[i] !== exp_pc[i]) $display("FAIL stall_pop%0d: got %h expected %h", i, p_pc[i], exp_pc[i]); else pass_cnt++;
    end
    chk_cnt++; if (g_addr[4] !== 32'h10) $display("FAIL stall_resume: got %h expected 00000010", g_addr[4]); else pass_cnt++;
  endtask

  task automatic test_redirect_drop();
    int stale = 0;
    reset_all(); lat = 4; i_inst_ready = 1'b1;
    repeat (3) tick();
    i_redirect_valid = 1'b1; i_redirect_pc = 32'h100;
    #1;
    chk_cnt++; if (o_imem_req !== 1'b0) $display("FAIL drop_req: got %0b expected 0", o_imem_req); else pass_cnt++;
    tick();
    i_redirect_valid = 1'b0;
    chk_cnt++; if (dut.r_drop_cnt !== 3'd3) $display("FAIL drop_cnt: got %0d expected 3", dut.r_drop_cnt); else pass_cnt++;
    chk_cnt++; if (o_inst_valid !== 1'b0) $display("FAIL drop_valid: got %0b expected 0", o_inst_valid); else pass_cnt++;
    clear_logs();
    repeat (10) tick();
    foreach (p_pc[i]) if (p_pc[i] < 32'h100) stale++;
    chk_cnt++; if (p_pc[0] !== 32'h100) $display("FAIL drop_first: got %h expected 00000100", p_pc[0]); else pass_cnt++;
    chk_cnt++; if (stale != 0 || p_pc.size() == 0) $display("FAIL drop_stale: got %0d stale of %0d expected 0", stale, p_pc.size()); else pass_cnt++;
    chk_cnt++; if (dut.r_drop_cnt !== 3'd0) $display("FAIL drop_done: got %0d expected 0", dut.r_drop_cnt); else pass_cnt++;
  endtask

  task automatic test_collision();
    reset_all(); lat = 1; i_inst_ready = 1'b1;
    repeat (2) tick();
    chk_cnt++; if ({o_inst_valid, i_imem_rvalid} !== 2'b11) $display("FAIL coll_setup: got %b expected 11", {o_inst_valid, i_imem_rvalid}); else pass_cnt++;
    i_redirect_valid = 1'b1; i_redirect_pc = 32'h200;
    tick();
    i_redirect_valid = 1'b0;
    chk_cnt++; if (o_inst_valid !== 1'b0) $display("FAIL coll_empty: got %0b expected 0", o_inst_valid); else pass_cnt++;
    chk_cnt++; if (dut.r_drop_cnt !== 3'd0) $display("FAIL coll_drop: got %0d expected 0", dut.r_drop_cnt); else pass_cnt++;
    tick();
    chk_cnt++; if (o_inst_valid !== 1'b0) $display("FAIL coll_gap: got %0b expected 0", o_inst_valid); else pass_cnt++;
    tick();
    chk_cnt++; if (o_inst_valid !== 1'b1 || o_inst_pc !== 32'h200) $display("FAIL coll_restart: got %0b/%h expected 1/00000200", o_inst_valid, o_inst_pc); else pass_cnt++;
    chk_cnt++; if (o_inst !== (32'h200 ^ K)) $display("FAIL coll_inst: got %h expected %h", o_inst, 32'h200 ^ K); else pass_cnt++;
  endtask

  task automatic test_wrap();
    i_redirect_valid = 1'b1; i_redirect_pc = 32'hFFFF_FFFC;
    tick();
    i_redirect_valid = 1'b0;
    clear_logs();
    repeat (6) tick();
    chk_cnt++; if (p_pc[0] !== 32'hFFFF_FFFC) $display("FAIL wrap_pc0: got %h expected fffffffc", p_pc[0]); else pass_cnt++;
    chk_cnt++; if (p_pc4[0] !== 32'h0) $display("FAIL wrap_pc4_0: got %h expected 00000000", p_pc4[0]); else pass_cnt++;
    chk_cnt++; if (p_pc[1] !== 32'h0) $display("FAIL wrap_pc1: got %h expected 00000000", p_pc[1]); else pass_cnt++;
    chk_cnt++; if (p_pc4[1] !== 32'h4) $display("FAIL wrap_pc4_1: got %h expected 00000004", p_pc4[1]); else pass_cnt++;
    i_redirect_valid = 1'b1; i_redirect_pc = 32'h103;
    tick();
    i_redirect_valid = 1'b0;
    clear_logs();
    repeat (5) tick();
    chk_cnt++; if (g_addr[0] !== 32'h100) $display("FAIL align_addr: got %h expected 00000100", g_addr[0]); else pass_cnt++;
    chk_cnt++; if (p_pc[0] !== 32'h100) $display("FAIL align_pc: got %h expected 00000100", p_pc[0]); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    reset_all(); lat = 3; i_inst_ready = 1'b0;
    repeat (5) tick();
    chk_cnt++; if (o_inst_valid !== 1'b1) $display("FAIL mid_setup: got %0b expected 1", o_inst_valid); else pass_cnt++;
    #2 rst = 1'b1;
    #1;
    chk_cnt++; if (o_imem_req !== 1'b0) $display("FAIL mid_req: got %0b expected 0", o_imem_req); else pass_cnt++;
    chk_cnt++; if (o_inst_valid !== 1'b0) $display("FAIL mid_valid: got %0b expected 0", o_inst_valid); else pass_cnt++;
    chk_cnt++; if (o_inst !== 32'h0) $display("FAIL mid_inst: got %h expected 0", o_inst); else pass_cnt++;
    chk_cnt++; if (o_inst_pc !== 32'h0 || o_inst_pc_plus_4 !== 32'h0) $display("FAIL mid_pc: got %h/%h expected 0/0", o_inst_pc, o_inst_pc_plus_4); else pass_cnt++;
    q_addr.delete(); q_due.delete(); i_imem_rvalid = 1'b0;
    @(negedge clk);
    rst = 1'b0; cyc = 0; clear_logs(); lat = 1; i_inst_ready = 1'b1;
    chk_cnt++; if (dut.r_drop_cnt !== 3'd0) $display("FAIL mid_drop: got %0d expected 0", dut.r_drop_cnt); else pass_cnt++;
    repeat (4) tick();
    chk_cnt++; if (g_addr[0] !== 32'h0) $display("FAIL mid_restart: got %h expected 00000000", g_addr[0]); else pass_cnt++;
    chk_cnt++; if (p_pc[0] !== 32'h0) $display("FAIL mid_first_pc: got %h expected 00000000", p_pc[0]); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect_drop();
    test_collision();
    test_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
